// File: rtl/scaler_v_linebuf.sv
// Vertical tap generator for the vertical cubic filter: keeps the three previous
// lines in RAM and presents four vertically aligned taps per input pixel.
module scaler_v_linebuf #(
    parameter int PIXEL_WIDTH    = 12,
    parameter int MAX_LINE_WIDTH = 2048,
    parameter int LCNT_WIDTH     = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] tap0_o,
    output logic [PIXEL_WIDTH-1:0] tap1_o,
    output logic [PIXEL_WIDTH-1:0] tap2_o,
    output logic [PIXEL_WIDTH-1:0] tap3_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic [LCNT_WIDTH-1:0]  line_cnt_o,
    output logic                   ovf_o
);

    localparam int AW = (MAX_LINE_WIDTH > 1) ? $clog2(MAX_LINE_WIDTH) : 1;
    localparam int XW = AW + 1;
    localparam logic [XW-1:0]         X_MAX = XW'(MAX_LINE_WIDTH);
    localparam logic [XW-1:0]         X_ONE = XW'(1);
    localparam logic [LCNT_WIDTH-1:0] LC_1  = LCNT_WIDTH'(1);
    localparam logic [LCNT_WIDTH-1:0] LC_2  = LCNT_WIDTH'(2);
    localparam logic [LCNT_WIDTH-1:0] LC_3  = LCNT_WIDTH'(3);

    typedef enum logic {
        WAIT_FRAME,
        ACTIVE
    } state_t;

    state_t                  state;
    logic [XW-1:0]           cnt;
    logic [XW-1:0]           len1;
    logic [XW-1:0]           len2;
    logic [XW-1:0]           len3;
    logic [LCNT_WIDTH-1:0]   line_cnt;
    logic                    ovf;

    logic                    frame_start;
    logic                    line_start;
    logic                    accept;
    logic                    in_range;
    logic                    ovf_base;
    logic                    ovf_cur;
    logic [XW-1:0]           x_cur;
    logic [XW-1:0]           len1_cur;
    logic [XW-1:0]           len2_cur;
    logic [XW-1:0]           len3_cur;
    logic [LCNT_WIDTH-1:0]   lc_cur;
    logic [3:1]              vld_cur;

    logic                    s1_valid;
    logic [PIXEL_WIDTH-1:0]  s1_di;
    logic [AW-1:0]           s1_addr;
    logic                    s1_hs;
    logic                    s1_vs;
    logic                    s1_wr;
    logic                    s1_ovf;
    logic [3:1]              s1_vld;
    logic [LCNT_WIDTH-1:0]   s1_lc;

    logic                    s2_valid;
    logic [PIXEL_WIDTH-1:0]  s2_di;
    logic [AW-1:0]           s2_addr;
    logic                    s2_hs;
    logic                    s2_vs;
    logic                    s2_wr;
    logic                    s2_ovf;
    logic [3:1]              s2_vld;
    logic [LCNT_WIDTH-1:0]   s2_lc;

    logic [PIXEL_WIDTH-1:0]  lb0 [MAX_LINE_WIDTH];
    logic [PIXEL_WIDTH-1:0]  lb1 [MAX_LINE_WIDTH];
    logic [PIXEL_WIDTH-1:0]  lb2 [MAX_LINE_WIDTH];
    logic [PIXEL_WIDTH-1:0]  rd0;
    logic [PIXEL_WIDTH-1:0]  rd1;
    logic [PIXEL_WIDTH-1:0]  rd2;

    // Each pixel carries its own line context (as updated by its own hs/vs), so
    // pixels still in flight across a line or frame boundary keep their masking.
    always_comb begin
        frame_start = de_i & hs_i & vs_i;
        line_start  = de_i & hs_i;
        accept      = de_i & ((state == ACTIVE) | frame_start);
        x_cur       = line_start ? '0 : cnt;
        len1_cur    = len1;
        len2_cur    = len2;
        len3_cur    = len3;
        lc_cur      = line_cnt;
        ovf_base    = ovf;
        if (frame_start) begin
            len1_cur = '0;
            len2_cur = '0;
            len3_cur = '0;
            lc_cur   = '0;
            ovf_base = 1'b0;
        end else if (line_start) begin
            len1_cur = cnt;
            len2_cur = len1;
            len3_cur = len2;
            lc_cur   = (line_cnt == '1) ? line_cnt : line_cnt + LC_1;
        end
        in_range = (x_cur < X_MAX);
        ovf_cur  = ovf_base | ~in_range;
        // A column reaches lbK only by passing through every shallower line, so a
        // tap is valid only if all intervening lines were at least that wide.
        vld_cur[1] = in_range && (lc_cur >= LC_1) && (x_cur < len1_cur);
        vld_cur[2] = vld_cur[1] && (lc_cur >= LC_2) && (x_cur < len2_cur);
        vld_cur[3] = vld_cur[2] && (lc_cur >= LC_3) && (x_cur < len3_cur);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WAIT_FRAME;
            cnt      <= '0;
            len1     <= '0;
            len2     <= '0;
            len3     <= '0;
            line_cnt <= '0;
            ovf      <= 1'b0;
        end else if (accept) begin
            state    <= ACTIVE;
            cnt      <= in_range ? x_cur + X_ONE : X_MAX;
            len1     <= len1_cur;
            len2     <= len2_cur;
            len3     <= len3_cur;
            line_cnt <= lc_cur;
            ovf      <= ovf_cur;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_di    <= '0;
            s1_addr  <= '0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_wr    <= 1'b0;
            s1_ovf   <= 1'b0;
            s1_vld   <= '0;
            s1_lc    <= '0;
            s2_valid <= 1'b0;
            s2_di    <= '0;
            s2_addr  <= '0;
            s2_hs    <= 1'b0;
            s2_vs    <= 1'b0;
            s2_wr    <= 1'b0;
            s2_ovf   <= 1'b0;
            s2_vld   <= '0;
            s2_lc    <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_di   <= di_i;
                s1_addr <= x_cur[AW-1:0];
                s1_hs   <= line_start;
                s1_vs   <= frame_start;
                s1_wr   <= in_range;
                s1_ovf  <= ovf_cur;
                s1_vld  <= vld_cur;
                s1_lc   <= lc_cur;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_di   <= s1_di;
                s2_addr <= s1_addr;
                s2_hs   <= s1_hs;
                s2_vs   <= s1_vs;
                s2_wr   <= s1_wr;
                s2_ovf  <= s1_ovf;
                s2_vld  <= s1_vld;
                s2_lc   <= s1_lc;
            end
        end
    end

    // Read for the pixel entering stage 2 while the pixel leaving it shifts its
    // column down the cascade; adjacent pixels never share an address.
    always_ff @(posedge clk) begin
        if (s1_valid) begin
            rd0 <= lb0[s1_addr];
            rd1 <= lb1[s1_addr];
            rd2 <= lb2[s1_addr];
        end
        if (s2_valid && s2_wr) begin
            lb0[s2_addr] <= s2_di;
            lb1[s2_addr] <= rd0;
            lb2[s2_addr] <= rd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap0_o     <= '0;
            tap1_o     <= '0;
            tap2_o     <= '0;
            tap3_o     <= '0;
            de_o       <= 1'b0;
            hs_o       <= 1'b0;
            vs_o       <= 1'b0;
            line_cnt_o <= '0;
            ovf_o      <= 1'b0;
        end else begin
            de_o <= s2_valid;
            hs_o <= s2_valid & s2_hs;
            vs_o <= s2_valid & s2_vs;
            if (s2_valid) begin
                tap0_o     <= s2_di;
                tap1_o     <= s2_vld[1] ? rd0 : '0;
                tap2_o     <= s2_vld[2] ? rd1 : '0;
                tap3_o     <= s2_vld[3] ? rd2 : '0;
                line_cnt_o <= s2_lc;
                ovf_o      <= s2_ovf;
            end
        end
    end

endmodule
